// File: rtl/rice_partition_scheduler.sv
// ---------------------------------------------------------------------------
// rice_partition_scheduler
//
// Schedules the Rice bit-packer for one FLAC subframe residual stream.
// Incoming residuals are clamped and folded to unsigned values. They are
// buffered one partition at a time into two ping-pong banks. For each full
// bank the drain side does the following:
//   - picks a Rice parameter k from the partition sum,
//   - issues one parameter command,
//   - issues one code command per residual,
//   - issues a flush command after the last partition of the block.
//
// Optional feature (compile-time macro RICE_BITCOUNT_EN):
//   When defined, the block adds output oBitCount. It holds the total number
//   of bits emitted for the finished block and is valid while oDone pulses.
//
// Ports:
//   iClock        clock, every register updates on its rising edge
//   iReset        synchronous active-high reset
//   iValid        a residual is present on iResidual
//   iResidual     16-bit signed residual
//   iLast         marks the last residual of the block (qualified by iValid)
//   oReady        accepting residuals (registered)
//   oEnable       command strobe to the packer
//   oChangeParam  command: emit the 4-bit Rice parameter oRiceParam
//   oFlush        command: flush the partial word and close the block
//   oRiceParam    selected k (during the parameter command)
//   oTotal        code length: upper + k + 1
//   oUpper        u >> k (unary part)
//   oLower        (1 << k) | low k bits of u
//   oDone         one-cycle pulse in the cycle after the flush command
//   oBitCount     (RICE_BITCOUNT_EN only) total bits of the finished block
// ---------------------------------------------------------------------------
module rice_partition_scheduler #(
  parameter int PART_LOG2 = 6,
  parameter int MAX_K     = 14
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iValid,
  input  logic [15:0] iResidual,
  input  logic        iLast,
  output logic        oReady,
  output logic        oEnable,
  output logic        oChangeParam,
  output logic        oFlush,
  output logic [3:0]  oRiceParam,
  output logic [15:0] oTotal,
  output logic [15:0] oUpper,
  output logic [15:0] oLower,
  output logic        oDone
`ifdef RICE_BITCOUNT_EN
  ,
  output logic [31:0] oBitCount
`endif
);

  localparam int PART_SIZE = 1 << PART_LOG2;
  localparam int CW        = PART_LOG2 + 1;  // counts 0..PART_SIZE

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CHOOSE = 3'd1;
  localparam logic [2:0] S_PARAM  = 3'd2;
  localparam logic [2:0] S_CODES  = 3'd3;
  localparam logic [2:0] S_FLUSH  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  // ---------------------------------------------------------------------
  // Input clamp and fold
  // ---------------------------------------------------------------------
  logic [15:0] clamp;
  logic [14:0] in_u;

  always_comb begin
    if ($signed(iResidual) > 16'sd16383)       clamp = 16'h3FFF;
    else if ($signed(iResidual) < -16'sd16384) clamp = 16'hC000;
    else                                       clamp = iResidual;
    // A negative r gives -2r-1 == ~(2r). Only 15 bits survive the clamp.
    in_u = clamp[15] ? ~{clamp[13:0], 1'b0} : {clamp[13:0], 1'b0};
  end

  // ---------------------------------------------------------------------
  // Fill side
  // ---------------------------------------------------------------------
  logic          ready_q, ready_d;
  logic          fill_bank_q, fill_bank_d;
  logic [CW-1:0] cnt_q;
  logic [23:0]   acc_q;
  logic [1:0]    full_q, full_d;
  logic [CW-1:0] bcount_q [2];
  logic [23:0]   bsum_q   [2];
  logic [1:0]    blast_q;

  logic          accept;
  logic [CW-1:0] cnt_inc;
  logic [23:0]   acc_inc;
  logic          close;

  assign accept  = iValid & ready_q;
  assign cnt_inc = cnt_q + CW'(1);
  assign acc_inc = acc_q + 24'(in_u);
  // Reaching PART_SIZE and iLast on the same sample yield one close.
  assign close   = accept & ((cnt_inc == CW'(PART_SIZE)) | iLast);

  // ---------------------------------------------------------------------
  // Drain side
  // ---------------------------------------------------------------------
  logic [2:0]          state_q, state_d;
  logic                drain_bank_q, drain_bank_d;
  logic [3:0]          k_q, k_d;
  logic [CW-1:0]       idx_q, idx_d;
  logic [14:0]         rd_q;
  logic [PART_LOG2-1:0] rd_idx;

  logic [CW-1:0] drain_count;
  logic [23:0]   drain_sum;
  logic          last_code;

  assign drain_count = bcount_q[drain_bank_q];
  assign drain_sum   = bsum_q[drain_bank_q];
  assign last_code   = (state_q == S_CODES) && (idx_q == drain_count - CW'(1));

  // The fill side only sets a bank that is empty, and the drain side only
  // clears the bank it is reading. So both updates never hit the same bit.
  always_comb begin
    full_d = full_q;
    if (close)     full_d[fill_bank_q]  = 1'b1;
    if (last_code) full_d[drain_bank_q] = 1'b0;
    fill_bank_d = close ? ~fill_bank_q : fill_bank_q;
    ready_d     = ~full_d[fill_bank_d];
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      ready_q     <= 1'b1;
      fill_bank_q <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
    end else begin
      ready_q     <= ready_d;
      fill_bank_q <= fill_bank_d;
      if (close) begin
        cnt_q <= '0;
        acc_q <= '0;
      end else if (accept) begin
        cnt_q <= cnt_inc;
        acc_q <= acc_inc;
      end
    end
  end

  // Per-bank descriptor: occupancy plus the count, sum and last flag
  // captured at close.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      always_ff @(posedge iClock) begin
        if (iReset) begin
          full_q[gi]   <= 1'b0;
          bcount_q[gi] <= '0;
          bsum_q[gi]   <= '0;
          blast_q[gi]  <= 1'b0;
        end else begin
          full_q[gi] <= full_d[gi];
          if (close && (fill_bank_q == 1'(gi))) begin
            bcount_q[gi] <= cnt_inc;
            bsum_q[gi]   <= acc_inc;
            blast_q[gi]  <= iLast;
          end
        end
      end
    end
  endgenerate

  // Residual storage for both banks: the bank bit selects the upper half.
  // The read runs one index ahead of the code being emitted. PARAM fetches
  // entry 0, and each CODES cycle fetches the next entry.
  logic [14:0] mem [2*PART_SIZE];

  always_comb begin
    rd_idx = '0;
    if (state_q == S_CODES) rd_idx = PART_LOG2'(idx_q + CW'(1));
  end

  always_ff @(posedge iClock) begin
    if (accept) mem[{fill_bank_q, cnt_q[PART_LOG2-1:0]}] <= in_u;
    rd_q <= mem[{drain_bank_q, rd_idx}];
  end

  // Parameter choice: ge[gi] is set when count << gi fits within the sum.
  // The predicate is monotone, so the highest set bit gives the largest k.
  logic [MAX_K:0] ge;
  logic [3:0]     k_sel;

  generate
    for (genvar gi = 0; gi <= MAX_K; gi++) begin : g_kcmp
      assign ge[gi] = ((32'(drain_count) << gi) <= 32'(drain_sum));
    end
  endgenerate

  always_comb begin
    k_sel = 4'd0;
    for (int i = 0; i <= MAX_K; i++) begin
      if (ge[i]) k_sel = 4'(i);
    end
  end

  always_comb begin
    state_d      = state_q;
    drain_bank_d = drain_bank_q;
    k_d          = k_q;
    idx_d        = idx_q;
    case (state_q)
      S_IDLE:   if (full_q[drain_bank_q]) state_d = S_CHOOSE;
      S_CHOOSE: begin
        k_d     = k_sel;
        state_d = S_PARAM;
      end
      S_PARAM: begin
        idx_d   = '0;
        state_d = S_CODES;
      end
      S_CODES: begin
        if (last_code) begin
          drain_bank_d = ~drain_bank_q;
          state_d      = blast_q[drain_bank_q] ? S_FLUSH : S_IDLE;
        end else begin
          idx_d = idx_q + CW'(1);
        end
      end
      S_FLUSH:  state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q      <= S_IDLE;
      drain_bank_q <= 1'b0;
      k_q          <= '0;
      idx_q        <= '0;
    end else begin
      state_q      <= state_d;
      drain_bank_q <= drain_bank_d;
      k_q          <= k_d;
      idx_q        <= idx_d;
    end
  end

  // ---------------------------------------------------------------------
  // Command outputs
  // ---------------------------------------------------------------------
  logic [15:0] code_u, code_upper, code_lower, code_total, low_mask;

  always_comb begin
    code_u     = {1'b0, rd_q};
    low_mask   = (16'd1 << k_q) - 16'd1;
    code_upper = code_u >> k_q;
    code_lower = (16'd1 << k_q) | (code_u & low_mask);
    code_total = code_upper + 16'(k_q) + 16'd1;
  end

  assign oReady       = ready_q;
  assign oEnable      = (state_q == S_PARAM) || (state_q == S_CODES) || (state_q == S_FLUSH);
  assign oChangeParam = (state_q == S_PARAM);
  assign oFlush       = (state_q == S_FLUSH);
  assign oRiceParam   = (state_q == S_PARAM) ? k_q : 4'd0;
  assign oTotal       = (state_q == S_CODES) ? code_total : 16'd0;
  assign oUpper       = (state_q == S_CODES) ? code_upper : 16'd0;
  assign oLower       = (state_q == S_CODES) ? code_lower : 16'd0;
  assign oDone        = (state_q == S_DONE);

`ifdef RICE_BITCOUNT_EN
  // The running bit total covers the 4-bit parameter field and every code.
  // The total is latched at flush, so it is stable while oDone pulses.
  logic [31:0] bitcnt_q;
  logic [31:0] bitcount_q;

  always_ff @(posedge iClock) begin
    if (iReset) begin
      bitcnt_q   <= '0;
      bitcount_q <= '0;
    end else begin
      case (state_q)
        S_PARAM: bitcnt_q <= bitcnt_q + 32'd4;
        S_CODES: bitcnt_q <= bitcnt_q + 32'(code_total);
        S_FLUSH: begin
          bitcount_q <= bitcnt_q;
          bitcnt_q   <= '0;
        end
        default: ;
      endcase
    end
  end

  assign oBitCount = bitcount_q;
`endif

endmodule

// File: doc/rice_partition_scheduler.md
Name: rice_partition_scheduler

Overview:
Sequences the Rice bit-packer for one FLAC subframe residual stream. Residuals stream in and are buffered per partition in two ping-pong banks. For each partition the block chooses a Rice parameter, then drives the packer command interface: one parameter change, one code per residual, and a flush at block end. It sits between the residual generator (LPC or fixed predictor) and the Rice bit-packer / RAM writer.

Parameters:
PART_LOG2, 6, log2 of partition size in samples (PART_SIZE = 2^PART_LOG2, legal range 2..8)
MAX_K, 14, largest Rice parameter the block may select (must be ≤ 14; parameter field is 4 bits)

Ports:
iClock  in  1  clock; all logic on its rising edge
iReset  in  1  synchronous, active-high reset
iValid  in  1  residual present on iResidual
iResidual  in  16  signed residual
iLast  in  1  qualifies iValid; marks the last residual of the block
oReady  out  1  accepting residuals; a transfer occurs when iValid and oReady are both high
oEnable  out  1  command-valid strobe to the packer; packer acts only when high
oChangeParam  out  1  command: emit 4-bit Rice parameter
oFlush  out  1  command: flush partial word and close block
oRiceParam  out  4  selected k
oTotal  out  16  upper + k + 1
oUpper  out  16  u >> k
oLower  out  16  (1 << k) | (u & ((1<<k)-1))
oDone  out  1  one-cycle pulse, the cycle after the flush command

Behaviour:
- Reset: every output is 0 except oReady, which is 1. Both banks are empty. Fill bank = 0, drain bank = 0, and the drain FSM is in IDLE. Reset mid-operation discards all buffered data and issues no further commands.
- Input clamp: residuals are saturated to -16384..16383. Fold is u = r≥0 ? 2r : -2r-1, giving a 15-bit u. With u ≤ 32767 and k ≤ 14, oTotal fits 16 bits without wrap.
- Fill: each accepted residual is written as u to the fill bank at index cnt, and cnt increments.
  - An accumulator adds u into a 24-bit sum.
  - The bank closes when cnt reaches PART_SIZE or iLast is accepted. On close, the bank stores count, sum and a last flag, is marked full, and fill switches to the other bank.
- oReady is registered. It is 0 while the current fill bank is full, i.e. both banks are occupied.
  - A bank freed by drain becomes visible on oReady the following cycle.
  - Close and reopen of the same bank in one cycle is not possible.
- Drain FSM states: IDLE, CHOOSE, PARAM, CODES, FLUSH, DONE.
  - IDLE → CHOOSE when the drain bank is full.
  - CHOOSE (1 cycle): k = largest k in 0..MAX_K with (count << k) ≤ sum; k = 0 if sum < count. The result is registered.
  - PARAM (1 cycle): oEnable=1, oChangeParam=1, oRiceParam=k.
  - CODES: one code per cycle for indices 0..count-1, with oEnable=1 and oChangeParam=oFlush=0. The bank RAM read is issued 1 cycle ahead, so the first code appears immediately after PARAM with no bubbles.
  - After the last code, the bank is marked empty and the drain bank toggles. If the last flag was set → FLUSH, otherwise → IDLE. A full next bank passes through IDLE in 1 cycle.
  - FLUSH (1 cycle): oEnable=1, oFlush=1.
  - DONE: oDone=1 for 1 cycle, then → IDLE.
- Idle cycles: oEnable=0, and all command outputs hold 0.
- Fill and drain run concurrently on different banks. Residuals of the next block may fill while the previous block flushes.
- iLast on a sample that also fills the partition: a single close with the last flag set; no empty partition is created.

Optional Feature:
RICE_BITCOUNT_EN
- Defined: adds output oBitCount (32 bits) and register bitcnt.
  - bitcnt += 4 on each PARAM command and += oTotal on each code; it is cleared on reset.
  - At FLUSH, oBitCount is loaded with the final bitcnt and valid when oDone pulses; bitcnt then clears for the next block.
- Undefined: the port and logic are absent. All other behaviour is identical.

Test Plan:
- PART_LOG2=2, residuals {0,0,0,0} with iLast on the 4th → PARAM k=0, then 4 codes of total=1, upper=0, lower=1, then FLUSH, then oDone the next cycle.
- PART_LOG2=2, residuals {3,-2,5,-1} with last → sum=20, k=2. Codes (total,upper,lower): (4,1,6), (3,0,7), (5,2,6), (3,0,5), then FLUSH. With RICE_BITCOUNT_EN, oBitCount=19.
- PART_LOG2=2, 6 residuals with last on the 6th → two PARAM commands, the second partition emits exactly 2 codes, and a single FLUSH after it.
- PART_LOG2=2, 12 residuals with iValid held high → oReady drops while both banks are full. All 12 codes are emitted in order with none lost or duplicated.
- Residual 16'h8000, sole sample with last → clamped to -16384, u=32767, k=14, upper=1, lower=0x7FFF, total=16.
- Assert iReset during CODES → oEnable is 0 the next cycle, oReady=1, and a new block afterwards starts with PARAM as normal.
